trig_pulse_rx: RTL
==================

TRIG_PULSE_RX -- requirements
Module: trig_pulse_rx

Interface
REQ-001 SHALL have port: clk  input  1  system clock, 200 MHz (5 ns tick).
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: coax_in  input  16  asynchronous trigger lines from the distribution board, active-high.
REQ-004 SHALL have port: chan_mask  input  16  1 = channel enabled.
REQ-005 SHALL have port: minticks  input  8  minimum qualifying pulse width in clk ticks; 0 is treated as 1.
REQ-006 SHALL have port: deadticks  input  8  holdoff after pulse end, in units of 4 ticks.
REQ-007 SHALL have port: trig_pulse  output  1  one-cycle strobe per accepted trigger.
REQ-008 SHALL have port: trig_chans  output  16  OR of masked channels seen during the accepted pulse.
REQ-009 SHALL have port: pulse_width  output  8  measured width of the last accepted pulse, saturating at 255.
REQ-010 SHALL have port: trig_count  output  32  accepted-trigger counter, wraps at 2^32.
REQ-011 SHALL have port: glitch_count  output  16  rejected-pulse counter, saturating at 0xFFFF.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: trig_time  output  32  timestamp of the last accepted trigger (see Configuration).

Function
REQ-014 SHALL pass each coax_in bit through a 2-flop synchronizer; define act = |(sync & chan_mask).
REQ-015 SHALL implement FSM states IDLE, MEASURE, WAITLOW, DEAD.
REQ-016 IDLE: when act=1, SHALL go to MEASURE, set width=1, chans=sync&chan_mask.
REQ-017 MEASURE: while act=1, SHALL do width+1 (saturate 255) and chans|=sync&chan_mask.
REQ-018 MEASURE: in the cycle width reaches max(minticks,1), SHALL assert trig_pulse for exactly one cycle, increment trig_count, and go to WAITLOW.
REQ-019 MEASURE: if act falls before qualification, SHALL increment glitch_count (saturating) and return to IDLE with no trig_pulse.
REQ-020 WAITLOW: SHALL continue width/chans accumulation; on act=0, SHALL latch pulse_width and trig_chans, clear the dead counter, and go to DEAD.
REQ-021 DEAD: SHALL ignore coax_in and count; after deadticks*4 ticks (computed at 10 bits, no overflow), SHALL go to IDLE; deadticks=0 gives a single DEAD cycle.
REQ-022 Latency: a clean edge on coax_in SHALL produce trig_pulse max(minticks,1)+2 cycles later (2 for sync, 1 state entry; minticks=1 gives 3 cycles).
REQ-023 A line stuck high SHALL remain in WAITLOW with pulse_width saturating at 255 and SHALL NOT retrigger.
REQ-024 chan_mask, minticks, and deadticks SHALL be sampled live each cycle; changes take effect on the next comparison.

Reset
REQ-025 rst=1 SHALL force IDLE and clear the synchronizers, trig_pulse, trig_chans, pulse_width, trig_count, glitch_count, trig_time, and the internal counters; busy SHALL be 0.
REQ-026 rst asserted mid-pulse or mid-DEAD SHALL abort with no trig_pulse; after release, a still-high line SHALL be treated as a new pulse.

Configuration
REQ-027 Macro TRIG_RX_TIMESTAMP_EN defined: a free-running 32-bit tick counter SHALL be latched into trig_time in the trig_pulse cycle.
REQ-028 Macro TRIG_RX_TIMESTAMP_EN undefined: trig_time SHALL be constant 0 and no timestamp counter SHALL exist.

Structure
REQ-029 Shared package trig_pkg SHALL hold the FSM state enum, NCHAN=16, DEAD_MULT=4, and the width constants for counters.
REQ-030 Synchronizer SHALL be a sub-module sync2 (parameterized width), instantiated once with width 16.

Verification
REQ-031 minticks=3, deadticks=2, mask=FFFF; coax_in[5] high 10 ticks -> one trig_pulse 5 cycles after the edge; trig_chans=0x0020; pulse_width=10; trig_count=1.
REQ-032 minticks=4; 2-tick pulse on bit 0 -> no trig_pulse; glitch_count=1; busy low 1 cycle after the line falls.
REQ-033 deadticks=2; second pulse starting 4 ticks after the first ends -> ignored; second pulse 12 ticks after the first ends -> accepted; trig_count=2.
REQ-034 mask=0x00FF; pulse on bit 9 only -> no trigger; overlapping pulses on bits 1 and 3 -> trig_chans=0x000A.
REQ-035 coax_in[0] held high 400 ticks -> exactly one trig_pulse; pulse_width=255 after release.
REQ-036 rst pulsed during MEASURE -> no trig_pulse; all counters 0; with TRIG_RX_TIMESTAMP_EN, trig_time equals the tick count at the strobe.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared definitions for the trigger pulse receiver.
// Holds the FSM state encoding, channel count, DEAD holdoff multiplier and
// the widths of the counters used by trig_pulse_rx.
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_WAITLOW,
    ST_DEAD
  } trig_state_t;

  localparam int unsigned NCHAN        = 16;
  localparam int unsigned DEAD_MULT    = 4;
  localparam int unsigned WIDTH_W      = 8;
  localparam int unsigned DEAD_W       = 10;
  localparam int unsigned TRIG_CNT_W   = 32;
  localparam int unsigned GLITCH_CNT_W = 16;
  localparam int unsigned TS_W         = 32;

  // A zero threshold behaves like a one-tick threshold.
  function automatic logic [WIDTH_W-1:0] eff_min(input logic [WIDTH_W-1:0] m);
    return (m == '0) ? WIDTH_W'(1) : m;
  endfunction

endpackage

// File: rtl/trig_pulse_rx_sync2.sv
// sync2: two-flop synchronizer, one pair of flops per bit.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears both stages
//   d    - asynchronous input bits
//   q    - synchronized bits (two clk ticks of delay)
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trig_pulse_rx.sv
// trig_pulse_rx: qualifies trigger pulses arriving on 16 asynchronous coax
// lines. A pulse on any enabled line that lasts at least max(minticks,1)
// ticks produces a one-cycle trig_pulse; shorter pulses count as glitches.
// After an accepted pulse ends, inputs are ignored for deadticks*4 ticks.
//
// Ports:
//   clk          - 200 MHz system clock
//   rst          - synchronous active-high reset
//   coax_in      - asynchronous trigger lines, active-high
//   chan_mask    - 1 = channel enabled (sampled live)
//   minticks     - minimum qualifying width in ticks, 0 treated as 1 (live)
//   deadticks    - holdoff after pulse end in units of 4 ticks (live)
//   trig_pulse   - one-cycle strobe per accepted trigger
//   trig_chans   - OR of masked channels seen during the accepted pulse
//   pulse_width  - width of last accepted pulse, saturating at 255
//   trig_count   - accepted triggers, wraps
//   glitch_count - rejected pulses, saturating at 0xFFFF
//   busy         - high whenever the FSM is not IDLE
//   trig_time    - timestamp of last accepted trigger
//
// Build option: define TRIG_RX_TIMESTAMP_EN to latch a free-running tick
// counter into trig_time on each strobe; otherwise trig_time is tied to 0.
module trig_pulse_rx
  import trig_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCHAN-1:0]        coax_in,
  input  logic [NCHAN-1:0]        chan_mask,
  input  logic [WIDTH_W-1:0]      minticks,
  input  logic [7:0]              deadticks,
  output logic                    trig_pulse,
  output logic [NCHAN-1:0]        trig_chans,
  output logic [WIDTH_W-1:0]      pulse_width,
  output logic [TRIG_CNT_W-1:0]   trig_count,
  output logic [GLITCH_CNT_W-1:0] glitch_count,
  output logic                    busy,
  output logic [TS_W-1:0]         trig_time
);

  trig_state_t        state, state_n;
  logic [NCHAN-1:0]   sync;
  logic [NCHAN-1:0]   masked;
  logic               act;
  logic [WIDTH_W-1:0] thr;
  logic [DEAD_W-1:0]  dead_lim;
  logic [DEAD_W-1:0]  dead_inc;

  logic [WIDTH_W-1:0] width, width_n, width_inc;
  logic [NCHAN-1:0]   chans, chans_n;
  logic [DEAD_W-1:0]  dead_cnt, dead_cnt_n;
  logic [WIDTH_W-1:0] pulse_width_n;
  logic [NCHAN-1:0]   trig_chans_n;
  logic               strobe;
  logic               glitch;

  sync2 #(.WIDTH(NCHAN)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (coax_in),
    .q   (sync)
  );

  assign masked    = sync & chan_mask;
  assign act       = |masked;
  assign thr       = eff_min(minticks);
  // At most 255*4 = 1020, so 10 bits never overflow.
  assign dead_lim  = DEAD_W'(deadticks) * DEAD_W'(DEAD_MULT);
  assign dead_inc  = dead_cnt + DEAD_W'(1);
  assign width_inc = (width == '1) ? width : width + WIDTH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    width_n       = width;
    chans_n       = chans;
    dead_cnt_n    = dead_cnt;
    pulse_width_n = pulse_width;
    trig_chans_n  = trig_chans;
    strobe        = 1'b0;
    glitch        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (act) begin
          state_n = ST_MEASURE;
          width_n = WIDTH_W'(1);
          chans_n = masked;
        end
      end
      ST_MEASURE: begin
        // Qualification is judged on the width already accumulated, so the
        // strobe lands in the cycle the count reaches the threshold.
        if (width >= thr) begin
          strobe  = 1'b1;
          state_n = ST_WAITLOW;
          if (act) begin
            width_n = width_inc;
            chans_n = chans | masked;
          end
        end else if (!act) begin
          glitch  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          width_n = width_inc;
          chans_n = chans | masked;
        end
      end
      ST_WAITLOW: begin
        if (act) begin
          width_n = width_inc;
          chans_n = chans | masked;
        end else begin
          pulse_width_n = width;
          trig_chans_n  = chans;
          dead_cnt_n    = '0;
          state_n       = ST_DEAD;
        end
      end
      ST_DEAD: begin
        // A zero limit still spends exactly one cycle here.
        if (dead_inc >= dead_lim) state_n = ST_IDLE;
        else                      dead_cnt_n = dead_inc;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width        <= '0;
      chans        <= '0;
      dead_cnt     <= '0;
      pulse_width  <= '0;
      trig_chans   <= '0;
      trig_count   <= '0;
      glitch_count <= '0;
    end else begin
      width       <= width_n;
      chans       <= chans_n;
      dead_cnt    <= dead_cnt_n;
      pulse_width <= pulse_width_n;
      trig_chans  <= trig_chans_n;
      if (strobe) trig_count <= trig_count + TRIG_CNT_W'(1);
      if (glitch && (glitch_count != '1))
        glitch_count <= glitch_count + GLITCH_CNT_W'(1);
    end
  end

  assign trig_pulse = strobe && !rst;
  assign busy       = (state != ST_IDLE);

`ifdef TRIG_RX_TIMESTAMP_EN
  logic [TS_W-1:0] tick_cnt;
  logic [TS_W-1:0] trig_time_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      trig_time_q <= '0;
    end else begin
      tick_cnt <= tick_cnt + TS_W'(1);
      if (strobe) trig_time_q <= tick_cnt;
    end
  end

  assign trig_time = trig_time_q;
`else
  assign trig_time = '0;
`endif

endmodule
